// File: rtl/i2c_arb.sv
// Two-requester arbiter in front of a single I2C master transmitter.
// Ownership lasts a whole transaction (through the word with bit 8 set); an idle owner is released on timeout.
module i2c_arb #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    input  logic [8:0] r0_data,
    output logic       r0_ready,
    input  logic       r1_valid,
    input  logic [8:0] r1_data,
    output logic       r1_ready,
    output logic [8:0] i2c_data,
    output logic       i2c_wr,
    input  logic       i2c_busy,
    output logic       locked,
    output logic       owner,
    output logic       abort
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [8:0]       data_nx;
    logic             owner_nx, locked_nx, wr_nx, abort_nx;
    logic             grant0, grant1;
    logic             xfer, own_valid, counting;
    logic [8:0]       xfer_data;

    // Grant selection: locked owner only, otherwise single valid or round-robin on a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state == S_IDLE && !i2c_busy) begin
            if (locked) begin
                grant0 = !owner && r0_valid;
                grant1 = owner && r1_valid;
            end else if (r0_valid && r1_valid) begin
                grant0 = owner;
                grant1 = !owner;
            end else begin
                grant0 = r0_valid;
                grant1 = r1_valid;
            end
        end
    end

    assign r0_ready  = grant0;
    assign r1_ready  = grant1;
    assign xfer      = grant0 | grant1;
    assign xfer_data = grant1 ? r1_data : r0_data;
    assign own_valid = owner ? r1_valid : r0_valid;
    assign counting  = (state == S_IDLE) && locked && !own_valid;

    always_comb begin
        state_nx  = state;
        data_nx   = i2c_data;
        owner_nx  = owner;
        locked_nx = locked;
        cnt_nx    = '0;
        wr_nx     = 1'b0;
        abort_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    state_nx  = S_ISSUE;
                    data_nx   = xfer_data;
                    owner_nx  = grant1;
                    locked_nx = !xfer_data[8];
                    wr_nx     = 1'b1;
                end else if (counting) begin
                    if (cnt == CNT_LAST) begin
                        locked_nx = 1'b0;
                        abort_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            S_ISSUE: state_nx = S_GUARD;
            // Busy is not trusted here: the transmitter raises it a cycle late
            S_GUARD: state_nx = S_WAIT;
            S_WAIT:  if (!i2c_busy) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            i2c_data <= '0;
            i2c_wr   <= 1'b0;
            owner    <= 1'b1;
            locked   <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            i2c_data <= data_nx;
            i2c_wr   <= wr_nx;
            owner    <= owner_nx;
            locked   <= locked_nx;
            abort    <= abort_nx;
        end
    end
endmodule

// File: tb/tb_i2c_arb.sv
// Bench for i2c_arb: directed scenarios plus random traffic, every cycle checked
// against a transaction-level reference model (acceptance windows, starvation count).
module tb_i2c_arb;
    localparam int unsigned TO = 8;

    logic       clk, rst_n;
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [8:0] r0_data, r1_data, i2c_data;
    logic       i2c_wr, i2c_busy, locked, owner, abort;

    i2c_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_data(r1_data), .r1_ready(r1_ready),
        .i2c_data(i2c_data), .i2c_wr(i2c_wr), .i2c_busy(i2c_busy),
        .locked(locked), .owner(owner), .abort(abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // values applied to the DUT at the next tick
    logic       v0, v1, bsy, rn;
    logic [8:0] d0, d1;

    // reference model: free = arbiter can take a word; age = cycles since the last accept
    bit         m_free, m_locked, m_owner, m_abort, m_wr;
    logic [8:0] m_data;
    int         m_starve, m_age;

    int         n_cmp, n_bad, cyc, abort_cnt, abort_cyc, base, base1;
    int         acc_n[2], acc_cyc[2];
    logic [8:0] wr_log[$];
    logic [8:0] s1_words[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_free = 1; m_locked = 0; m_owner = 1; m_abort = 0; m_wr = 0;
        m_data = '0; m_starve = 0; m_age = 0;
    endtask

    function automatic logic [8:0] rand_word();
        logic [8:0] w;
        w    = 9'($urandom);
        w[8] = ($urandom_range(0, 2) == 0);
        return w;
    endfunction

    // One clock: apply inputs, compare every output with the model, advance the model.
    task automatic tick();
        bit         can, acc, who;
        logic [8:0] w;
        @(negedge clk);
        r0_valid = v0; r0_data = d0; r1_valid = v1; r1_data = d1;
        i2c_busy = bsy; rst_n = rn;
        #1;
        can = m_free && !bsy && rn;
        if (m_locked) begin
            who = m_owner;
            acc = can && (m_owner ? v1 : v0);
        end else if (v0 && v1) begin
            who = !m_owner;
            acc = can;
        end else begin
            who = v1;
            acc = can && (v0 || v1);
        end
        check("r0_ready", 32'(r0_ready), 32'(acc && !who));
        check("r1_ready", 32'(r1_ready), 32'(acc && who));
        check("i2c_wr",   32'(i2c_wr),   32'(m_wr));
        check("i2c_data", 32'(i2c_data), 32'(m_data));
        check("locked",   32'(locked),   32'(m_locked));
        check("owner",    32'(owner),    32'(m_owner));
        check("abort",    32'(abort),    32'(m_abort));
        if (r0_ready && r0_valid) begin acc_n[0]++; acc_cyc[0] = cyc; end
        if (r1_ready && r1_valid) begin acc_n[1]++; acc_cyc[1] = cyc; end
        if (i2c_wr) wr_log.push_back(i2c_data);
        if (abort) begin abort_cnt++; abort_cyc = cyc; end
        w = who ? d1 : d0;
        if (!rn) begin
            model_reset();
        end else begin
            m_wr    = acc;
            m_abort = 0;
            if (acc) begin
                m_data = w; m_owner = who; m_locked = !w[8];
                m_starve = 0; m_free = 0; m_age = 1;
            end else if (m_free) begin
                if (m_locked && !(m_owner ? v1 : v0)) begin
                    m_starve++;
                    if (m_starve == int'(TO)) begin
                        m_locked = 0; m_abort = 1; m_starve = 0;
                    end
                end else begin
                    m_starve = 0;
                end
            end else if (m_age >= 3 && !bsy) begin
                m_free = 1;
            end else begin
                m_age++;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one word until accepted, then emulate the transmitter busy for blen cycles.
    task automatic send(input bit who, input logic [8:0] word, input int blen);
        bit got;
        got = 0;
        if (who) begin v1 = 1; d1 = word; end else begin v0 = 1; d0 = word; end
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            got = who ? r1_ready : r0_ready;
        end
        check("send_accepted", 32'(got), 32'(1));
        if (who) v1 = 0; else v0 = 0;
        tick();
        bsy = 1;
        idle(blen);
        bsy = 0;
        tick();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; abort_cnt = 0; abort_cyc = 0;
        acc_n[0] = 0; acc_n[1] = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
        v0 = 0; v1 = 0; d0 = '0; d1 = '0; bsy = 0; rn = 0;
        r0_valid = 0; r1_valid = 0; r0_data = '0; r1_data = '0; i2c_busy = 0; rst_n = 0;
        s1_words[0] = 9'h0A0; s1_words[1] = 9'h0FF; s1_words[2] = 9'h155;
        @(posedge clk);
        #1;
        model_reset();
        rn = 1;

        // single requester, three-word transaction
        wr_log.delete();
        for (int i = 0; i < 3; i++) begin
            send(0, s1_words[i], 10);
            check("s1_owner", 32'(owner), 32'(0));
            check("s1_locked", 32'(locked), 32'(i < 2));
        end
        check("s1_wr_count", 32'(wr_log.size()), 32'(3));
        for (int i = 0; i < 3 && i < wr_log.size(); i++)
            check("s1_word", 32'(wr_log[i]), 32'(s1_words[i]));

        // tie straight after reset, then round robin
        rn = 0; tick(); rn = 1;
        wr_log.delete();
        v0 = 1; d0 = 9'h111; v1 = 1; d1 = 9'h122;
        tick();
        check("s2_tie_r0", 32'(r0_ready), 32'(1));
        check("s2_tie_r1", 32'(r1_ready), 32'(0));
        for (int i = 0; i < 40 && wr_log.size() < 2; i++) tick();
        v0 = 0; v1 = 0;
        check("s2_wr_count", 32'(wr_log.size()), 32'(2));
        if (wr_log.size() >= 2) begin
            check("s2_first", 32'(wr_log[0]), 32'(9'h111));
            check("s2_second", 32'(wr_log[1]), 32'(9'h122));
        end
        idle(6);

        // lock held against a continuously valid r1
        base1 = acc_n[1];
        send(0, 9'h050, 0);
        v1 = 1; d1 = 9'h1AA;
        idle(6); send(0, 9'h051, 0);
        idle(6); send(0, 9'h152, 0);
        check("s3_r1_held", 32'(acc_n[1]), 32'(base1));
        for (int i = 0; i < 20 && acc_n[1] == base1; i++) tick();
        v1 = 0;
        check("s3_r1_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(4));
        idle(6);

        // idle timeout releases the owner
        base = abort_cnt;
        send(0, 9'h030, 0);
        v1 = 1; d1 = 9'h1BB;
        for (int i = 0; i < 40 && abort_cnt == base; i++) tick();
        check("s4_abort_delay", 32'(abort_cyc - acc_cyc[0]), 32'(12));
        check("s4_r1_take", 32'(acc_cyc[1] - abort_cyc), 32'(0));
        v1 = 0;
        idle(10);
        check("s4_abort_once", 32'(abort_cnt - base), 32'(1));

        // busy in IDLE blocks acceptance
        bsy = 1; v1 = 1; d1 = 9'h1EE;
        base = acc_n[0] + acc_n[1]; base1 = wr_log.size();
        idle(50);
        check("s5_no_accept", 32'(acc_n[0] + acc_n[1]), 32'(base));
        check("s5_no_wr", 32'(wr_log.size()), 32'(base1));
        bsy = 0; tick();
        check("s5_accept_now", 32'(r1_ready), 32'(1));
        v1 = 0;
        idle(6);

        // reset during WAIT of a locked transaction
        v0 = 1; d0 = 9'h061;
        for (int i = 0; i < 20 && !r0_ready; i++) tick();
        v0 = 0; tick();
        bsy = 1; idle(4);
        check("s6_pre_locked", 32'(locked), 32'(1));
        rn = 0; tick(); rn = 1; bsy = 0; tick();
        check("s6_locked", 32'(locked), 32'(0));
        check("s6_owner", 32'(owner), 32'(1));
        check("s6_abort", 32'(abort), 32'(0));
        check("s6_wr", 32'(i2c_wr), 32'(0));
        check("s6_data", 32'(i2c_data), 32'(0));
        v0 = 1; d0 = 9'h1C0; v1 = 1; d1 = 9'h1C1;
        tick();
        check("s6_tie_r0", 32'(r0_ready), 32'(1));
        check("s6_tie_r1", 32'(r1_ready), 32'(0));
        v0 = 0; v1 = 0;
        idle(6);

        // random traffic, occasional abandonment, busy bursts and resets
        for (int c = 0; c < 3000; c++) begin
            if (v0 && r0_ready) v0 = 0;
            else if (v0 && $urandom_range(0, 29) == 0) v0 = 0;
            if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1; d0 = rand_word(); end
            if (v1 && r1_ready) v1 = 0;
            else if (v1 && $urandom_range(0, 29) == 0) v1 = 0;
            if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1; d1 = rand_word(); end
            if (bsy) bsy = ($urandom_range(0, 3) != 0);
            else     bsy = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
